// File: rtl/note_pkg.sv
// note_pkg: note-memory word layout shared by the recording and playback paths.
// Each word is {key, count}; playback begins at the first address, never at 0.
package note_pkg;

  localparam int NOTE_ADDR_W     = 11;
  localparam int NOTE_KEY_W      = 8;
  localparam int NOTE_CNT_W      = 4;
  localparam int NOTE_KEY_LSB    = 4;
  localparam int NOTE_CNT_LSB    = 0;
  localparam int NOTE_FIRST_ADDR = 1;

endpackage

// File: rtl/note_timer.sv
// note_timer: loadable down-counter stepped by TickEn, used for note duration and gap hold.
// The counter is one bit wider than the count field so a load of count+1 never overflows.
module note_timer
  import note_pkg::*;
#(
  parameter int W = NOTE_CNT_W + 1
) (
  input  logic         PCLK,
  input  logic         RST_N,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expire
);

  logic [W-1:0] remaining_reg;

  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      remaining_reg <= '0;
    end else if (load) begin
      remaining_reg <= load_val;
    end else if (tick && (remaining_reg != '0)) begin
      remaining_reg <= remaining_reg - W'(1);
    end
  end

  // High on the tick that brings the count to zero.
  assign expire = tick && (remaining_reg == W'(1));

endmodule

// File: rtl/playback_unit.sv
// playback_unit: replays {key,count} words from the note RAM as a timed key stream.
// Define PLAYBACK_LOOP_EN to restart at the first address after each pass instead of stopping.
module playback_unit
  import note_pkg::*;
#(
  parameter int ADDR_W = NOTE_ADDR_W,
  parameter int KEY_W  = NOTE_KEY_W,
  parameter int CNT_W  = NOTE_CNT_W
) (
  input  logic                     PCLK,
  input  logic                     RST_N,
  input  logic                     PlayEn,
  input  logic                     TickEn,
  input  logic [ADDR_W-1:0]        EndAddr,
  input  logic [KEY_W+CNT_W-1:0]   RdData,
  output logic                     ReadEn,
  output logic [ADDR_W-1:0]        Address,
  output logic [KEY_W-1:0]         Key,
  output logic                     Busy,
  output logic                     Done
);

  localparam int TW = CNT_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_PLAY,
    ST_GAP
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [KEY_W-1:0]  key_reg, key_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              play_en_d_reg;

  logic              play_rise;
  logic              tmr_load;
  logic [TW-1:0]     tmr_load_val;
  logic              tmr_expire;

  note_timer #(.W(TW)) u_timer (
    .PCLK     (PCLK),
    .RST_N    (RST_N),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .tick     (TickEn),
    .expire   (tmr_expire)
  );

  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      key_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      play_en_d_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      key_reg       <= key_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      play_en_d_reg <= PlayEn;
    end
  end

  assign play_rise = PlayEn && !play_en_d_reg;

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    key_next     = key_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;

    // Dropping PlayEn aborts silently from any active state.
    if ((state_reg != ST_IDLE) && !PlayEn) begin
      state_next = ST_IDLE;
      key_next   = '0;
      busy_next  = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (play_rise) begin
            if (EndAddr != '0) begin
              addr_next  = ADDR_W'(NOTE_FIRST_ADDR);
              busy_next  = 1'b1;
              state_next = ST_FETCH;
            end else begin
              done_next = 1'b1;
            end
          end
        end
        ST_FETCH: begin
          state_next = ST_WAIT;
        end
        ST_WAIT: begin
          key_next     = RdData[NOTE_KEY_LSB +: KEY_W];
          tmr_load     = 1'b1;
          tmr_load_val = {1'b0, RdData[NOTE_CNT_LSB +: CNT_W]} + TW'(1);
          state_next   = ST_PLAY;
        end
        ST_PLAY: begin
          if (tmr_expire) begin
            key_next     = '0;
            tmr_load     = 1'b1;
            tmr_load_val = TW'(1);
            state_next   = ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_expire) begin
            if (addr_reg == EndAddr) begin
              done_next = 1'b1;
`ifdef PLAYBACK_LOOP_EN
              addr_next  = ADDR_W'(NOTE_FIRST_ADDR);
              state_next = ST_FETCH;
`else
              busy_next  = 1'b0;
              state_next = ST_IDLE;
`endif
            end else begin
              addr_next  = addr_reg + ADDR_W'(1);
              state_next = ST_FETCH;
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign ReadEn  = (state_reg == ST_FETCH);
  assign Address = addr_reg;
  assign Key     = key_reg;
  assign Busy    = busy_reg;
  assign Done    = done_reg;

endmodule

// File: tb/tb_playback_unit.sv
// tb_playback_unit: table-driven playback traces plus hand-written corner sequences.
// Honours PLAYBACK_LOOP_EN for the end-of-list expectations.
module tb_playback_unit;

  logic        PCLK    = 1'b0;
  logic        RST_N   = 1'b0;
  logic        PlayEn  = 1'b0;
  logic        TickEn  = 1'b0;
  logic [10:0] EndAddr = '0;
  logic [11:0] RdData  = '0;
  logic        ReadEn;
  logic [10:0] Address;
  logic [7:0]  Key;
  logic        Busy;
  logic        Done;

  logic [11:0] mem [0:2047];
  int          rd_count = 0;
  int          errors   = 0;
  int          checks   = 0;

  // One playback: three memory words, end address, and the expected key per tick
  // as (key, tick-count) segments; segment 0 sits in the lowest slot.
  typedef struct packed {
    logic [11:0]      w1;
    logic [11:0]      w2;
    logic [11:0]      w3;
    logic [10:0]      end_addr;
    logic [2:0]       segs;
    logic [5:0][7:0]  k;
    logic [5:0][4:0]  n;
  } vec_t;

  vec_t vecs [5];

  playback_unit dut (
    .PCLK    (PCLK),
    .RST_N   (RST_N),
    .PlayEn  (PlayEn),
    .TickEn  (TickEn),
    .EndAddr (EndAddr),
    .RdData  (RdData),
    .ReadEn  (ReadEn),
    .Address (Address),
    .Key     (Key),
    .Busy    (Busy),
    .Done    (Done)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) begin
    if (ReadEn) begin
      RdData   <= mem[Address];
      rd_count <= rd_count + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Three idle cycles then a TickEn cycle; Key is checked while the tick is pending.
  task automatic tick_key(input logic [7:0] exp);
    TickEn = 1'b0;
    cyc(3);
    TickEn = 1'b1;
    chk("tick_key", 32'(Key), 32'(exp));
    chk("tick_no_done", 32'(Done), 32'd0);
    cyc(1);
    TickEn = 1'b0;
  endtask

  task automatic start_play(input logic [11:0] w1, input logic [11:0] w2,
                            input logic [11:0] w3, input logic [10:0] ea);
    mem[1]  = w1;
    mem[2]  = w2;
    mem[3]  = w3;
    EndAddr = ea;
    PlayEn  = 1'b0;
    TickEn  = 1'b0;
    cyc(2);
    PlayEn = 1'b1;
    cyc(1);
  endtask

  task automatic check_end(input string tag);
    chk({tag, "_done"}, 32'(Done), 32'd1);
`ifdef PLAYBACK_LOOP_EN
    chk({tag, "_busy_loop"}, 32'(Busy), 32'd1);
    chk({tag, "_addr_loop"}, 32'(Address), 32'd1);
`else
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
`endif
    cyc(1);
    chk({tag, "_done_once"}, 32'(Done), 32'd0);
    PlayEn = 1'b0;
    cyc(1);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    start_play(v.w1, v.w2, v.w3, v.end_addr);
    chk("start_readen", 32'(ReadEn), 32'd1);
    chk("start_addr", 32'(Address), 32'd1);
    chk("start_busy", 32'(Busy), 32'd1);
    for (int s = 0; s < int'(v.segs); s++) begin
      for (int i = 0; i < int'(v.n[s]); i++) begin
        tick_key(v.k[s]);
      end
    end
    check_end("vec_end");
    $display("vec %0d: words %h %h %h end=%0d errors so far=%0d", id, v.w1, v.w2, v.w3, v.end_addr, errors);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_before;

    for (int a = 0; a < 2048; a++) mem[a] = '0;

    vecs[0] = '{w1: 12'h413, w2: 12'h420, w3: 12'h000, end_addr: 11'd2, segs: 3'd4,
                k: {8'h00, 8'h00, 8'h00, 8'h42, 8'h00, 8'h41},
                n: {5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd4}};
    vecs[1] = '{w1: 12'h55F, w2: 12'h000, w3: 12'h000, end_addr: 11'd1, segs: 3'd2,
                k: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55},
                n: {5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd16}};
    vecs[2] = '{w1: 12'h300, w2: 12'h300, w3: 12'h000, end_addr: 11'd2, segs: 3'd4,
                k: {8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h30},
                n: {5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd1}};
    vecs[3] = '{w1: 12'h002, w2: 12'h7A1, w3: 12'h000, end_addr: 11'd2, segs: 3'd4,
                k: {8'h00, 8'h00, 8'h00, 8'h7A, 8'h00, 8'h00},
                n: {5'd0, 5'd0, 5'd1, 5'd2, 5'd1, 5'd3}};
    vecs[4] = '{w1: 12'h122, w2: 12'h230, w3: 12'h341, end_addr: 11'd3, segs: 3'd6,
                k: {8'h00, 8'h34, 8'h00, 8'h23, 8'h00, 8'h12},
                n: {5'd1, 5'd2, 5'd1, 5'd1, 5'd1, 5'd3}};

    // Reset state
    cyc(2);
    chk("rst_key", 32'(Key), 32'd0);
    chk("rst_addr", 32'(Address), 32'd0);
    chk("rst_readen", 32'(ReadEn), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    RST_N = 1'b1;
    cyc(2);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Empty recording: Done one cycle later, no memory reads
    rd_before = rd_count;
    start_play(12'h000, 12'h000, 12'h000, 11'd0);
    chk("empty_done", 32'(Done), 32'd1);
    chk("empty_readen", 32'(ReadEn), 32'd0);
    chk("empty_busy", 32'(Busy), 32'd0);
    cyc(1);
    chk("empty_done_once", 32'(Done), 32'd0);
    cyc(4);
    chk("empty_no_reads", 32'(rd_count), 32'(rd_before));
    chk("empty_key", 32'(Key), 32'd0);
    PlayEn = 1'b0;
    cyc(1);
    $display("empty: errors so far=%0d", errors);

    // Note boundary timing and TickEn ignored during FETCH/WAIT
    start_play(12'h413, 12'h420, 12'h000, 11'd2);
    for (int i = 0; i < 3; i++) tick_key(8'h41);
    cyc(3);
    TickEn = 1'b1;
    chk("bnd_last_key", 32'(Key), 32'h41);
    cyc(1);
    TickEn = 1'b0;
    chk("bnd_key_zero", 32'(Key), 32'd0);
    cyc(3);
    TickEn = 1'b1;
    cyc(1);
    chk("bnd_fetch_readen", 32'(ReadEn), 32'd1);
    chk("bnd_fetch_addr", 32'(Address), 32'd2);
    chk("bnd_fetch_key", 32'(Key), 32'd0);
    cyc(1);
    chk("bnd_wait_key", 32'(Key), 32'd0);
    cyc(1);
    TickEn = 1'b0;
    chk("bnd_next_key", 32'(Key), 32'h42);
    tick_key(8'h42);
    tick_key(8'h00);
    check_end("bnd_end");
    $display("boundary: errors so far=%0d", errors);

    // Abort mid-PLAY of note 3, then restart
    start_play(12'h122, 12'h230, 12'h341, 11'd3);
    for (int i = 0; i < 3; i++) tick_key(8'h12);
    tick_key(8'h00);
    tick_key(8'h23);
    tick_key(8'h00);
    tick_key(8'h34);
    cyc(1);
    PlayEn = 1'b0;
    cyc(1);
    chk("abort_key", 32'(Key), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("abort_no_done", 32'(Done), 32'd0);
    end
    PlayEn = 1'b1;
    cyc(1);
    chk("restart_addr", 32'(Address), 32'd1);
    chk("restart_readen", 32'(ReadEn), 32'd1);
    cyc(2);
    chk("restart_key", 32'(Key), 32'h12);
    PlayEn = 1'b0;
    cyc(1);
    $display("abort: errors so far=%0d", errors);

    // Asynchronous reset mid-note
    start_play(12'h55F, 12'h000, 12'h000, 11'd1);
    for (int i = 0; i < 3; i++) tick_key(8'h55);
    cyc(1);
    #3;
    RST_N = 1'b0;
    #1;
    chk("arst_key", 32'(Key), 32'd0);
    chk("arst_busy", 32'(Busy), 32'd0);
    chk("arst_readen", 32'(ReadEn), 32'd0);
    chk("arst_addr", 32'(Address), 32'd0);
    chk("arst_done", 32'(Done), 32'd0);
    PlayEn = 1'b0;
    cyc(1);
    RST_N = 1'b1;
    cyc(2);
    chk("arst_after_key", 32'(Key), 32'd0);
    $display("async reset: errors so far=%0d", errors);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/playback_unit.md
# playback_unit

Reads the key/duration words written into the note memory by the recording path and replays them as a timed key stream for the tone generator. Each 12-bit word is {key[7:0], count[3:0]}. Playback starts at address 1, runs through `EndAddr` inclusive, and holds each key for its recorded duration measured in `TickEn` strobes. The block sits between the shared note RAM (read port) and the sound-output path.

## Interface
- `ADDR_W`, 11: memory address width.
- `KEY_W`, 8: key code width.
- `CNT_W`, 4: duration field width.
- `PCLK` input 1: playback clock, rising edge.
- `RST_N` input 1: reset, asynchronous, active-low.
- `PlayEn` input 1: level. Rising edge starts playback. Low aborts playback.
- `TickEn` input 1: one-cycle duration strobe, same rate as the record clock.
- `EndAddr` input 11: last written address. 0 means nothing is recorded.
- `RdData` input 12: memory read data. Valid exactly 1 cycle after `ReadEn`.
- `ReadEn` output 1: memory read strobe, one cycle wide.
- `Address` output 11: memory read address.
- `Key` output 8: replayed key code. 0 means silence.
- `Busy` output 1: high from the start of playback until done or abort.
- `Done` output 1: one-cycle pulse after the last note's gap completes.

## Operation
- Reset values: state IDLE; `Address`=0, `Key`=0, `ReadEn`=0, `Busy`=0, `Done`=0. The remaining counter is cleared.
- States: IDLE, FETCH, WAIT, PLAY, GAP.
- **IDLE**
  - On a `PlayEn` rising edge with `EndAddr`≠0: `Address`←1, `Busy`←1, go to FETCH.
  - On a `PlayEn` rising edge with `EndAddr`=0: pulse `Done` and stay in IDLE.
- **FETCH**: `ReadEn`=1 for one cycle, then go to WAIT.
- **WAIT**: latch `RdData`.
  - `Key`←RdData[11:4].
  - remaining←RdData[3:0]+1, held in a 5-bit counter so count 15 gives 16 ticks without overflow.
  - Go to PLAY.
- **PLAY**: on each `TickEn`, decrement remaining. When it reaches 0, `Key`←0 and go to GAP.
- **GAP**: `Key`=0 for one `TickEn`, which separates repeated identical keys. Then:
  - If `Address`==`EndAddr`, end of list (see Configuration).
  - Otherwise `Address`←`Address`+1 and go to FETCH.
- A word whose key field is 0 plays as silence for its full duration. It is not skipped.
- `Address` increments mod 2^`ADDR_W`. If `EndAddr` is below the current address, playback wraps through 0 and stops on the equality match.
- `PlayEn` low in any non-IDLE state: next cycle `Key`=0, `Busy`=0, state IDLE, no `Done` pulse.
- `EndAddr` is sampled only at the GAP compare. A change mid-playback takes effect at the next note boundary.

## Timing
- The PLAYBACK_LOOP_EN restart edge case is specified under Configuration.
- Start latency: `PlayEn` rising edge (sampled) → `ReadEn` at +1 cycle → `Key` valid at +3 cycles.
- Note boundary: last `TickEn` of a note → `Key`=0 on the next cycle. The next `Key` appears 3 cycles after the GAP `TickEn`.
- A note with count c occupies exactly c+1 `TickEn` strobes, plus one gap strobe.
- `TickEn` arriving during FETCH or WAIT is ignored.
- `Done` is asserted in the same cycle that `Busy` falls.

## Configuration
- `PLAYBACK_LOOP_EN` defined: on end of list, `Address`←1 and go to FETCH. `Done` pulses once per pass and `Busy` stays high. Playback continues until `PlayEn` goes low.
- Macro undefined: on end of list, pulse `Done`, drop `Busy`, and go to IDLE. A fresh `PlayEn` rising edge is required to restart.

## Structure
- `note_pkg` (shared with the recording path) holds:
  - `KEY_W`, `CNT_W`, `ADDR_W`
  - the 12-bit word layout constants: key field [11:4], count field [3:0]
  - the first-address constant (1)
- The playback state enum is local to this block.
- One sub-module, `note_timer`:
  - Loads count+1, decrements on `TickEn`, flags zero.
  - Reused for the GAP hold with a load value of 1.

## Test plan
- Memory {1:0x413, 2:0x420}, `EndAddr`=2, `TickEn` every 4 cycles, `PlayEn` rising edge:
  - `Key`=0x41 for 4 ticks, 0 for 1 tick, 0x42 for 1 tick, 0 for 1 tick.
  - Then `Done` pulses and `Busy` falls.
- `EndAddr`=0 and a `PlayEn` rising edge: `ReadEn` never asserts, `Done` pulses 1 cycle later, `Key` stays 0.
- Word 0x55F: `Key`=0x55 held exactly 16 ticks, confirming the counter does not overflow.
- Two identical words 0x300, `EndAddr`=2: `Key` goes 0x30, 0, 0x30, with a 1-tick gap visible between them.
- `PlayEn` dropped mid-PLAY of note 3: next cycle `Key`=0, `Busy`=0, no `Done`. A later rising edge restarts at `Address`=1.
- With `PLAYBACK_LOOP_EN`, `EndAddr`=1: after the GAP, `Address` returns to 1 and `Done` pulses each pass. `RST_N` low mid-note forces every output to 0 asynchronously.
